// File: rtl/mem_fifo_loader_pkg.sv
// Shared definitions for the MAC-array fill stage.
//   DATA_WIDTH / MEM_WIDTH / NUM_ROWS : default geometry (8-bit elements,
//                                       64-bit memory words, 8 A rows)
//   loader_state_t                    : loader FSM state encoding
package mem_fifo_loader_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int MEM_WIDTH  = 64;
   localparam int NUM_ROWS   = 8;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      SHIFT,
      DONE
   } loader_state_t;

endpackage

// File: rtl/mem_fifo_loader_serializer.sv
// word_serializer: holds one memory word and emits it one element at a time,
// least-significant element first.
//   clk, rst : clock and synchronous active-high reset
//   load     : capture din and restart at element 0
//   din      : MEM_WIDTH-bit word to serialize
//   active   : the owner wants to emit an element this cycle
//   stall    : the downstream target cannot accept; hold the current element
//   dout     : current element (low DATA_WIDTH bits of the shift register)
//   valid    : element is being handed over this cycle (active & ~stall)
//   last     : current element is the final one of the word
module word_serializer #(
   parameter int DATA_WIDTH = 8,
   parameter int MEM_WIDTH  = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [MEM_WIDTH-1:0]  din,
   input  logic                  active,
   input  logic                  stall,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  valid,
   output logic                  last
);

   localparam int NELEM = MEM_WIDTH / DATA_WIDTH;
   localparam int IDX_W = (NELEM > 1) ? $clog2(NELEM) : 1;

   logic [MEM_WIDTH-1:0] shreg;
   logic [IDX_W-1:0]     elem_idx;

   assign valid = active & ~stall;
   assign last  = (elem_idx == IDX_W'(NELEM - 1));
   assign dout  = shreg[DATA_WIDTH-1:0];

   // Shifting in zeros leaves the register clear once a word is drained,
   // so the shared FIFO data bus idles at zero between words.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg    <= '0;
         elem_idx <= '0;
      end else if (load) begin
         shreg    <= din;
         elem_idx <= '0;
      end else if (valid) begin
         shreg    <= shreg >> DATA_WIDTH;
         elem_idx <= last ? '0 : elem_idx + 1'b1;
      end
   end

endmodule

// File: rtl/mem_fifo_loader.sv
// mem_fifo_loader: fills the MAC array input FIFOs from memory. Reads
// NUM_ROWS+1 words over an Avalon-MM read port (word 0 = B vector,
// words 1..NUM_ROWS = A rows) and writes each word byte-by-byte into its FIFO.
//   clk, rst           : clock, synchronous active-high reset
//   start              : pulse; starts a load from IDLE or DONE
//   address, read      : Avalon read request (word address)
//   readdata           : Avalon read data, qualified by readdatavalid
//   waitrequest        : Avalon stall, request held while high
//   fifo_data          : byte shared by all FIFO write ports
//   wrreq_b, wrreq_a   : write strobes for the B FIFO and the A FIFOs
//   wrfull_b, wrfull_a : FIFO full flags
//   busy, done         : load in progress / load complete (level)
module mem_fifo_loader #(
   parameter int          DATA_WIDTH = mem_fifo_loader_pkg::DATA_WIDTH,
   parameter int          MEM_WIDTH  = mem_fifo_loader_pkg::MEM_WIDTH,
   parameter int          NUM_ROWS   = mem_fifo_loader_pkg::NUM_ROWS,
   parameter logic [31:0] BASE_ADDR  = 32'd0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic [31:0]           address,
   output logic                  read,
   input  logic [MEM_WIDTH-1:0]  readdata,
   input  logic                  readdatavalid,
   input  logic                  waitrequest,
   output logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  wrreq_b,
   output logic [NUM_ROWS-1:0]   wrreq_a,
   input  logic                  wrfull_b,
   input  logic [NUM_ROWS-1:0]   wrfull_a,
   output logic                  busy,
   output logic                  done
);

   import mem_fifo_loader_pkg::*;

   localparam int WIDX_W = $clog2(NUM_ROWS + 1);

   loader_state_t     state, state_nxt;
   logic [WIDX_W-1:0] word_idx;
   logic              tgt_full;
   logic              ser_load;
   logic              ser_valid;
   logic              ser_last;
   logic              word_end;
   logic              final_word;
   logic              can_start;

   assign can_start  = (state == IDLE) || (state == DONE);
   assign word_end   = ser_valid & ser_last;
   assign final_word = (word_idx == WIDX_W'(NUM_ROWS));
   assign ser_load   = (state == WAIT) & readdatavalid;

   // Only the FIFO that the current word is headed for can stall the shift.
   always_comb begin
      tgt_full = wrfull_b;
      for (int r = 0; r < NUM_ROWS; r++) begin
         if (word_idx == WIDX_W'(r + 1)) tgt_full = wrfull_a[r];
      end
   end

   word_serializer #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_WIDTH  (MEM_WIDTH)
   ) u_ser (
      .clk    (clk),
      .rst    (rst),
      .load   (ser_load),
      .din    (readdata),
      .active (state == SHIFT),
      .stall  (tgt_full),
      .dout   (fifo_data),
      .valid  (ser_valid),
      .last   (ser_last)
   );

   // One-hot strobe decode: word 0 feeds B, word r+1 feeds A FIFO r.
   always_comb begin
      wrreq_b = 1'b0;
      wrreq_a = '0;
      if (word_idx == '0) wrreq_b = ser_valid;
      for (int r = 0; r < NUM_ROWS; r++) begin
         if (word_idx == WIDX_W'(r + 1)) wrreq_a[r] = ser_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         word_idx <= '0;
      end else begin
         state <= state_nxt;
         if (can_start && start) begin
            word_idx <= '0;
         end else if (word_end && !final_word) begin
            word_idx <= word_idx + 1'b1;
         end
      end
   end

   // read and address come straight from the state, so they stay stable for
   // as long as waitrequest holds the FSM in REQ.
   always_comb begin
      state_nxt = state;
      read      = 1'b0;
      address   = '0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = REQ;
         end
         REQ: begin
            busy    = 1'b1;
            read    = 1'b1;
            address = BASE_ADDR + 32'(word_idx);
            if (!waitrequest) state_nxt = WAIT;
         end
         WAIT: begin
            busy = 1'b1;
            if (readdatavalid) state_nxt = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (word_end) state_nxt = final_word ? DONE : REQ;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_nxt = REQ;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_fifo_loader.sv
// Bench for mem_fifo_loader: a 2-cycle-latency memory model with optional
// waitrequest and FIFO-full injection, a table of load scenarios, and
// hand-written sequences for reset mid-load and start handling.
module tb_mem_fifo_loader;

   logic        clk;
   logic        rst;
   logic        start;
   logic [31:0] address;
   logic        read;
   logic [63:0] readdata;
   logic        readdatavalid;
   logic        waitrequest;
   logic [7:0]  fifo_data;
   logic        wrreq_b;
   logic [7:0]  wrreq_a;
   logic        wrfull_b;
   logic [7:0]  wrfull_a;
   logic        busy;
   logic        done;

   mem_fifo_loader #(
      .DATA_WIDTH (8),
      .MEM_WIDTH  (64),
      .NUM_ROWS   (8),
      .BASE_ADDR  (32'd0)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .address       (address),
      .read          (read),
      .readdata      (readdata),
      .readdatavalid (readdatavalid),
      .waitrequest   (waitrequest),
      .fifo_data     (fifo_data),
      .wrreq_b       (wrreq_b),
      .wrreq_a       (wrreq_a),
      .wrfull_b      (wrfull_b),
      .wrfull_a      (wrfull_a),
      .busy          (busy),
      .done          (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string name;
      int    stall_addr;   // -1: no waitrequest
      int    stall_cyc;
      int    full_cyc;     // cycles wrfull_a[2] held at row-2 byte 3
      int    pattern;      // 1: word 0 = 8877665544332211
      int    exp_hold;     // cycles read held at stall_addr
   } vec_t;

   vec_t        tbl [4];
   int          vecs;
   int          fails;

   // memory / fault-injection model state
   int          lat_cnt;
   logic [31:0] lat_addr;
   logic [31:0] stall_addr;
   int          wr_budget;
   int          full_budget;
   int          pattern;
   logic        force_rdv;

   // observation logs
   int          n_str;
   int          str_tgt [200];
   logic [7:0]  str_dat [200];
   int          n_addr;
   logic [31:0] acc_addr [40];
   int          row2_cnt;
   int          done_rises;
   logic        done_q;
   int          hold_cnt;
   int          stall_seen;
   int          onehot_err;
   int          full_wr_err;

   function automatic logic [63:0] mem_word(input logic [31:0] k, input int pat);
      logic [7:0] b;
      b = k[7:0];
      if (pat == 1 && k == 32'd0) return 64'h8877665544332211;
      return {8{b}};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_logs();
      n_str       = 0;
      n_addr      = 0;
      row2_cnt    = 0;
      done_rises  = 0;
      hold_cnt    = 0;
      stall_seen  = 0;
      onehot_err  = 0;
      full_wr_err = 0;
   endtask

   task automatic log_strobe(input int tgt);
      if (n_str < 200) begin
         str_tgt[n_str] = tgt;
         str_dat[n_str] = fifo_data;
      end
      n_str++;
   endtask

   // One clock: drive the model inputs at the falling edge, then sample.
   task automatic step();
      @(negedge clk);
      readdatavalid = 1'b0;
      if (force_rdv) begin
         readdatavalid = 1'b1;
         readdata      = 64'hDEADBEEFCAFEF00D;
      end
      if (lat_cnt > 0) begin
         lat_cnt--;
         if (lat_cnt == 0) begin
            readdatavalid = 1'b1;
            readdata      = mem_word(lat_addr, pattern);
         end
      end
      waitrequest = 1'b0;
      if (read) begin
         if (address == stall_addr && wr_budget > 0) begin
            waitrequest = 1'b1;
            wr_budget--;
         end else begin
            lat_cnt  = 2;
            lat_addr = address;
            if (n_addr < 40) acc_addr[n_addr] = address;
            n_addr++;
         end
      end
      wrfull_a = '0;
      if (row2_cnt == 3 && full_budget > 0) begin
         wrfull_a[2] = 1'b1;
         full_budget--;
      end
      #1;
      if (read && address == stall_addr) hold_cnt++;
      if (wrfull_a[2]) begin
         if (!wrreq_b && wrreq_a == '0) stall_seen++;
         if (wrreq_a[2]) full_wr_err++;
      end
      if ($countones(wrreq_a) + int'(wrreq_b) > 1) onehot_err++;
      if (wrreq_b) log_strobe(0);
      for (int r = 0; r < 8; r++) begin
         if (wrreq_a[r]) log_strobe(r + 1);
      end
      if (wrreq_a[2]) row2_cnt++;
      if (done && !done_q) done_rises++;
      done_q = done;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic run_to_done(input int extra_start_cyc, output logic ok);
      ok = 1'b0;
      for (int c = 0; c < 600; c++) begin
         if (c == extra_start_cyc) start = 1'b1;
         step();
         start = 1'b0;
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
      for (int c = 0; c < 3; c++) step();
   endtask

   task automatic check_load(input string tag, input int pat);
      int          bad_order;
      int          bad_addr;
      logic [63:0] w;
      logic [7:0]  eb;
      bad_order = 0;
      bad_addr  = 0;
      for (int i = 0; i < 72 && i < n_str; i++) begin
         w  = mem_word(32'(i / 8), pat);
         eb = w[8 * (i % 8) +: 8];
         if (str_tgt[i] != i / 8 || str_dat[i] !== eb) bad_order++;
      end
      for (int i = 0; i < 9 && i < n_addr; i++) begin
         if (acc_addr[i] != 32'(i)) bad_addr++;
      end
      check({tag, "_strobes"}, 64'(n_str), 64'd72);
      check({tag, "_order_errs"}, 64'(bad_order), 64'd0);
      check({tag, "_reads"}, 64'(n_addr), 64'd9);
      check({tag, "_addr_errs"}, 64'(bad_addr), 64'd0);
      check({tag, "_done_rises"}, 64'(done_rises), 64'd1);
      check({tag, "_onehot_errs"}, 64'(onehot_err), 64'd0);
      check({tag, "_end_busy_done"}, {62'd0, busy, done}, 64'd1);
   endtask

   initial begin
      logic ok;
      tbl[0] = '{"plain",    -1, 0, 0, 0, 0};
      tbl[1] = '{"waitreq",   4, 3, 0, 0, 4};
      tbl[2] = '{"bytes",    -1, 0, 0, 1, 0};
      tbl[3] = '{"fullstall",-1, 0, 5, 0, 0};

      vecs = 0;
      fails = 0;
      rst = 1'b1;
      start = 1'b0;
      readdata = '0;
      readdatavalid = 1'b0;
      waitrequest = 1'b0;
      wrfull_b = 1'b0;
      wrfull_a = '0;
      lat_cnt = 0;
      lat_addr = '0;
      stall_addr = '1;
      wr_budget = 0;
      full_budget = 0;
      pattern = 0;
      force_rdv = 1'b0;
      done_q = 1'b0;
      clear_logs();

      step();
      start = 1'b1;   // start together with reset: reset wins
      step();
      start = 1'b0;
      check("reset_outputs",
            {address, 7'd0, read, fifo_data, wrreq_b, wrreq_a, busy, done, 4'd0}, 64'd0);
      rst = 1'b0;
      step();
      check("start_with_rst_ignored", {62'd0, busy, read}, 64'd0);

      for (int v = 0; v < 4; v++) begin
         clear_logs();
         stall_addr  = (tbl[v].stall_addr < 0) ? '1 : 32'(tbl[v].stall_addr);
         wr_budget   = tbl[v].stall_cyc;
         full_budget = tbl[v].full_cyc;
         pattern     = tbl[v].pattern;
         pulse_start();
         check({tbl[v].name, "_busy_after_start"}, {62'd0, busy, done}, 64'd2);
         run_to_done(-1, ok);
         check({tbl[v].name, "_done_reached"}, 64'(ok), 64'd1);
         check_load(tbl[v].name, tbl[v].pattern);
         check({tbl[v].name, "_read_hold"}, 64'(hold_cnt), 64'(tbl[v].exp_hold));
         check({tbl[v].name, "_full_stall_cycles"}, 64'(stall_seen), 64'(tbl[v].full_cyc));
         check({tbl[v].name, "_write_while_full"}, 64'(full_wr_err), 64'd0);
      end
      stall_addr = '1;
      pattern = 0;

      // Reset in the middle of word 5, then a stray readdatavalid.
      clear_logs();
      pulse_start();
      for (int c = 0; c < 600 && n_str < 43; c++) step();
      check("mid_reset_reached", 64'(n_str), 64'd43);
      rst = 1'b1;
      step();
      rst = 1'b0;
      lat_cnt = 0;
      check("mid_reset_outputs", {54'd0, read, wrreq_b, wrreq_a, busy, done}, 64'd0);
      force_rdv = 1'b1;
      step();
      force_rdv = 1'b0;
      for (int c = 0; c < 4; c++) step();
      check("late_rdv_ignored", {31'd0, busy, 32'(n_str)}, 64'd43);
      clear_logs();
      pulse_start();
      run_to_done(-1, ok);
      check("reload_done_reached", 64'(ok), 64'd1);
      check_load("reload", 0);

      // start while busy is ignored; start in DONE restarts a full load.
      clear_logs();
      pulse_start();
      run_to_done(20, ok);
      check("busy_start_done_reached", 64'(ok), 64'd1);
      check_load("busy_start", 0);
      clear_logs();
      pulse_start();
      check("restart_clears_done", {62'd0, busy, done}, 64'd2);
      run_to_done(-1, ok);
      check("restart_done_reached", 64'(ok), 64'd1);
      check_load("restart", 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
